// File: rtl/dsp_mac_pipe_if.sv
// Beat/result bus between the sample source and the MAC pipe.
// The master drives beats and observes frame results; the slave is the MAC.
interface dsp_mac_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic signed [WIDTH-1:0]     in_a;
  logic signed [WIDTH-1:0]     in_b;
  logic                        in_first;
  logic                        in_last;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last,
    input  out_valid, out_data, out_sat, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last,
    output out_valid, out_data, out_sat, out_ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-accumulate: one beat per clock, one rounded and
// saturated dot-product result per first/last framed block of beats.
// Latency from a beat to its effect on the output is PIPE+2 clocks.
module dsp_mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int PIPE      = 2,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  dsp_mac_pipe_if.slave  mac
);

  localparam int PW      = 2 * WIDTH;
  localparam int AW1     = ACC_WIDTH + 1;
  localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic RND_EN = (SHIFT > 0);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Round half up and arithmetic shift, one bit wider so the add cannot wrap.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    ext          = AW1'(acc);
    rnd          = '0;
    rnd[RND_BIT] = RND_EN;
    return (ext + rnd) >>> SHIFT;
  endfunction

  // Clamp to the signed output range; returns {clamped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [ACC_WIDTH:0] r
  );
    if (r > OUT_MAX)      return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    else if (r < OUT_MIN) return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    else                  return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  logic                    vld_p0_q;
  logic                    first_p0_q;
  logic                    last_p0_q;
  logic signed [WIDTH-1:0] a_p0_q;
  logic signed [WIDTH-1:0] b_p0_q;

  logic signed [PW-1:0]    prod_p1_q [PIPE];
  logic [PIPE-1:0]         vld_p1_q;
  logic [PIPE-1:0]         first_p1_q;
  logic [PIPE-1:0]         last_p1_q;

  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        wrap_d;
  logic                        wrap_q;
  logic                        fire_d;
  logic                        fire_q;

  logic [OUT_WIDTH:0]          sat_pack;
  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        out_sat_q;
  logic                        out_ovf_q;

  // ---- stage p0: input capture ----
  // Beat qualifier; cleared by reset so inputs are ignored while reset is high.
  always_ff @(posedge clock) begin
    if (reset) vld_p0_q <= 1'b0;
    else       vld_p0_q <= mac.in_valid;
  end

  // Operand and framing capture, meaningful only alongside vld_p0_q.
  always_ff @(posedge clock) begin
    first_p0_q <= mac.in_first;
    last_p0_q  <= mac.in_last;
    a_p0_q     <= mac.in_a;
    b_p0_q     <= mac.in_b;
  end

  // ---- stage p1: PIPE product registers ----
  // Valid shift chain for the product pipeline; reset discards beats in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q <= '0;
    end else begin
      vld_p1_q[0] <= vld_p0_q;
      for (int i = 1; i < PIPE; i++) vld_p1_q[i] <= vld_p1_q[i-1];
    end
  end

  // Full-width product and its framing markers travel together.
  always_ff @(posedge clock) begin
    prod_p1_q[0]  <= a_p0_q * b_p0_q;
    first_p1_q[0] <= first_p0_q;
    last_p1_q[0]  <= last_p0_q;
    for (int i = 1; i < PIPE; i++) begin
      prod_p1_q[i]  <= prod_p1_q[i-1];
      first_p1_q[i] <= first_p1_q[i-1];
      last_p1_q[i]  <= last_p1_q[i-1];
    end
  end

  // ---- stage p2: accumulate ----
  // Next accumulator and sticky wrap flag; a same-sign add whose sum flips sign wrapped.
  always_comb begin
    p_ext  = ACC_WIDTH'(prod_p1_q[PIPE-1]);
    sum    = acc_q + p_ext;
    acc_d  = acc_q;
    wrap_d = wrap_q;
    fire_d = vld_p1_q[PIPE-1] & last_p1_q[PIPE-1];
    if (vld_p1_q[PIPE-1]) begin
      if (first_p1_q[PIPE-1]) begin
        acc_d  = p_ext;
        wrap_d = 1'b0;
      end else begin
        acc_d = sum;
        if ((acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
            (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
          wrap_d = 1'b1;
      end
    end
  end

  // Accumulator state; acc starts at zero so beats before any first add onto 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
      fire_q <= fire_d;
    end
  end

  // ---- stage p3: round, shift, saturate ----
  // acc_q already includes the frame's last beat when fire_q is set.
  always_comb begin
    sat_pack = saturate(round_shift(acc_q));
  end

  // Result registers pulse valid for one cycle and otherwise hold the last result.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= fire_q;
      if (fire_q) begin
        out_data_q <= sat_pack[OUT_WIDTH-1:0];
        out_sat_q  <= sat_pack[OUT_WIDTH];
        out_ovf_q  <= wrap_q;
      end
    end
  end

  assign mac.out_valid = out_valid_q;
  assign mac.out_data  = out_data_q;
  assign mac.out_sat   = out_sat_q;
  assign mac.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: four configurations share one beat stream, each with
// its own reference model and queue of expected frame results.
module tb_dsp_mac_pipe;

  localparam int NCFG = 4;
  localparam int PIPE_C [NCFG] = '{2, 1, 4, 2};
  localparam int ACC_C  [NCFG] = '{40, 40, 40, 32};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_first = 1'b0;
  logic s_last  = 1'b0;
  logic signed [15:0] s_a = '0;
  logic signed [15:0] s_b = '0;
  longint cyc = 0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    longint due;
    longint data;
    bit     sat;
    bit     ovf;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint wrap_to(input longint x, input int w);
    longint t;
    t = x <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    dsp_mac_pipe_if #(.WIDTH(16), .OUT_WIDTH(16)) bus ();
    assign bus.in_valid = s_valid;
    assign bus.in_first = s_first;
    assign bus.in_last  = s_last;
    assign bus.in_a     = s_a;
    assign bus.in_b     = s_b;

    dsp_mac_pipe #(
      .WIDTH(16), .ACC_WIDTH(ACC_C[g]), .PIPE(PIPE_C[g]), .SHIFT(15), .OUT_WIDTH(16)
    ) dut (
      .clock(clk),
      .reset(rst),
      .mac  (bus)
    );

    exp_t   q[$];
    longint m_acc = 0;
    bit     m_wrap = 1'b0;
    bit     rst_seen = 1'b1;
    longint last_data = 0;
    bit     last_sat = 1'b0;
    bit     last_ovf = 1'b0;

    // Reference model: observes each beat at the edge that accepts it.
    always @(posedge clk) begin
      longint p, s, r;
      exp_t e;
      rst_seen = rst;
      if (rst) begin
        m_acc  = 0;
        m_wrap = 1'b0;
        q.delete();
      end else if (s_valid) begin
        p = longint'(s_a) * longint'(s_b);
        if (s_first) begin
          m_acc  = p;
          m_wrap = 1'b0;
        end else begin
          s = m_acc + p;
          m_acc = wrap_to(s, ACC_C[g]);
          if (m_acc != s) m_wrap = 1'b1;
        end
        if (s_last) begin
          r = (m_acc + 16384) >>> 15;
          e.due = cyc + PIPE_C[g] + 3;
          e.sat = (r > 32767) || (r < -32768);
          e.data = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
          e.ovf = m_wrap;
          q.push_back(e);
        end
      end
    end

    // Output checker, sampled mid-cycle.
    always @(negedge clk) begin
      exp_t e;
      if (rst_seen) begin
        check_val($sformatf("c%0d_rst_vld", g), longint'(bus.out_valid), 0);
        check_val($sformatf("c%0d_rst_data", g), longint'(bus.out_data), 0);
        check_val($sformatf("c%0d_rst_sat", g), longint'(bus.out_sat), 0);
        check_val($sformatf("c%0d_rst_ovf", g), longint'(bus.out_ovf), 0);
        last_data = 0; last_sat = 1'b0; last_ovf = 1'b0;
      end else if (bus.out_valid) begin
        if (q.size() == 0) begin
          check_val($sformatf("c%0d_spurious_vld", g), longint'(bus.out_valid), 0);
        end else begin
          e = q.pop_front();
          check_val($sformatf("c%0d_latency", g), cyc, e.due);
          check_val($sformatf("c%0d_data", g), longint'(bus.out_data), e.data);
          check_val($sformatf("c%0d_sat", g), longint'(bus.out_sat), longint'(e.sat));
          check_val($sformatf("c%0d_ovf", g), longint'(bus.out_ovf), longint'(e.ovf));
        end
        last_data = longint'(bus.out_data);
        last_sat  = bus.out_sat;
        last_ovf  = bus.out_ovf;
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          check_val($sformatf("c%0d_missing_vld", g), longint'(bus.out_valid), 1);
          void'(q.pop_front());
        end
        check_val($sformatf("c%0d_hold_data", g), longint'(bus.out_data), last_data);
        check_val($sformatf("c%0d_hold_flags", g),
                  longint'({bus.out_sat, bus.out_ovf}), longint'({last_sat, last_ovf}));
      end
    end
  end

  task automatic beat(input int a, input int b, input bit f, input bit l);
    @(negedge clk);
    s_valid = 1'b1; s_a = 16'(a); s_b = 16'(b); s_first = f; s_last = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    @(negedge clk); rst = 1'b0;
    // One-beat frame
    beat(16384, 16384, 1, 1); idle(8);
    // Three beats with gaps
    beat(16384, 16384, 1, 0); idle(2);
    beat(16384, 16384, 0, 0); idle(1);
    beat(16384, 16384, 0, 1); idle(8);
    // Rounding near zero, back-to-back one-beat frames
    beat(-1, 16384, 1, 1);
    beat(-1, 16385, 1, 1);
    beat(1, 16384, 1, 1); idle(8);
    // Saturation both ways
    beat(-32768, -32768, 1, 1); idle(2);
    beat(32767, -32768, 1, 0);
    beat(32767, -32768, 0, 1); idle(8);
    // Wrap at 32-bit accumulator, next frame immediately after
    beat(-32768, -32768, 1, 0);
    beat(-32768, -32768, 0, 1);
    beat(100, 200, 1, 1); idle(8);
    // Beat after a last without a new first accumulates
    beat(16384, 16384, 1, 1);
    beat(16384, 16384, 0, 1); idle(8);
    // Reset with beats in flight, including a beat offered during reset
    beat(1000, 1000, 1, 0);
    beat(1000, 1000, 0, 1);
    @(negedge clk); rst = 1'b1; s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1;
    idle(2);
    @(negedge clk); rst = 1'b0;
    // First beat after reset with no first marker adds onto zero
    beat(16384, 16384, 0, 1);
    beat(-20000, 30000, 1, 0);
    beat(12345, -23456, 0, 1); idle(8);
    // Random frames with random gaps
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        beat($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
             k == 0, k == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(12);
    check_val("c0_drain", g_dut[0].q.size(), 0);
    check_val("c1_drain", g_dut[1].q.size(), 0);
    check_val("c2_drain", g_dut[2].q.size(), 0);
    check_val("c3_drain", g_dut[3].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
